// File: rtl/thread_scheduler_pkg.sv
// Shared types and constants for the multithreaded fetch scheduler.
//   n_threads     : number of hardware threads
//   threadid_t    : thread identifier type
//   max_inflight  : default cap on issued-but-not-retired instructions per thread
//   sched_state_t : per-thread fetch state (RUN or DRAIN after redirect/exception)
package thread_scheduler_pkg;

    localparam int n_threads    = 8;
    localparam int max_inflight = 8;

    typedef logic [$clog2(n_threads)-1:0] threadid_t;

    typedef enum logic {
        SCHED_RUN   = 1'b0,
        SCHED_DRAIN = 1'b1
    } sched_state_t;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req   : request vector, one bit per requester
//   last  : index of the previous winner; the scan starts at last+1 and wraps
//   grant : index of the winner (0 when nothing is requested)
//   grant_oh : one-hot form of grant, all zero when nothing is requested
//   any   : at least one request is present
module thread_scheduler_rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic [N-1:0] grant_oh,
    output logic         any
);

    // Scanning from the farthest offset down to the nearest lets the
    // nearest requester after last overwrite any farther one.
    always_comb begin
        int c;
        c        = 0;
        any      = 1'b0;
        grant    = '0;
        grant_oh = '0;
        for (int k = N; k >= 1; k--) begin
            c = int'(last) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (req[c[W-1:0]]) begin
                any   = 1'b1;
                grant = c[W-1:0];
            end
        end
        if (any) begin
            grant_oh[grant] = 1'b1;
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Per-cycle fetch thread selector.
//   clk, rst          : clock, synchronous active-high reset
//   thread_en         : per-thread enable mask (0 = never granted)
//   stalled           : per-thread d-cache stall
//   wb_valid/wb_thread: an instruction of wb_thread leaves the pipeline
//   redirect_en/_thread, exc_en/_thread : PC change or fault for a thread
//   sched_valid/scheduler_thread : registered grant into the IF stage
//   draining          : per-thread DRAIN state
//   err_underflow     : sticky, a retire was seen with the thread counter at 0
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int N_THREADS    = n_threads,
    parameter int TID_W        = $bits(threadid_t),
    parameter int MAX_INFLIGHT = max_inflight,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thread_en,
    input  logic [N_THREADS-1:0] stalled,
    input  logic                 wb_valid,
    input  logic [TID_W-1:0]     wb_thread,
    input  logic                 redirect_en,
    input  logic [TID_W-1:0]     redirect_thread,
    input  logic                 exc_en,
    input  logic [TID_W-1:0]     exc_thread,
    output logic                 sched_valid,
    output logic [TID_W-1:0]     scheduler_thread,
    output logic [N_THREADS-1:0] draining,
    output logic                 err_underflow
);

    logic                 r_valid;
    logic [TID_W-1:0]     r_thread;
    logic [TID_W-1:0]     r_last;
    logic                 r_err;

    logic [N_THREADS-1:0] w_elig;
    logic [N_THREADS-1:0] w_grant_oh;
    logic [N_THREADS-1:0] w_underflow;
    logic [N_THREADS-1:0] w_draining;
    logic [TID_W-1:0]     w_grant;
    logic                 w_any;

    thread_scheduler_rr_arbiter #(
        .N (N_THREADS),
        .W (TID_W)
    ) u_arb (
        .req      (w_elig),
        .last     (r_last),
        .grant    (w_grant),
        .grant_oh (w_grant_oh),
        .any      (w_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_THREADS; gi++) begin : g_thr
            logic [CNT_W-1:0] r_cnt;
            sched_state_t     r_state;
            logic             w_hit;
            logic             w_inc;
            logic             w_dec;

            // A redirect or exception in this very cycle already blocks fetch,
            // so no stale instruction slips in before the DRAIN state registers.
            assign w_hit = (redirect_en && (redirect_thread == TID_W'(gi))) ||
                           (exc_en && (exc_thread == TID_W'(gi)));
            assign w_inc = w_grant_oh[gi];
            assign w_dec = wb_valid && (wb_thread == TID_W'(gi));

            assign w_elig[gi] = thread_en[gi] && !stalled[gi] &&
                                (r_state == SCHED_RUN) &&
                                (r_cnt < CNT_W'(MAX_INFLIGHT)) && !w_hit;

            assign w_underflow[gi] = w_dec && !w_inc && (r_cnt == '0);
            assign w_draining[gi]  = (r_state == SCHED_DRAIN);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_state <= SCHED_RUN;
                end else begin
                    if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - 1'b1;
                    end

                    case (r_state)
                        SCHED_RUN: begin
                            if (w_hit) begin
                                r_state <= SCHED_DRAIN;
                            end
                        end
                        SCHED_DRAIN: begin
                            // Leave only once every stale instruction has retired.
                            if (!w_hit && (r_cnt == '0)) begin
                                r_state <= SCHED_RUN;
                            end
                        end
                        default: r_state <= SCHED_RUN;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_thread <= '0;
            r_last   <= TID_W'(N_THREADS - 1);
            r_err    <= 1'b0;
        end else begin
            r_err <= r_err | (|w_underflow);
            if (w_any) begin
                r_valid  <= 1'b1;
                r_thread <= w_grant;
                r_last   <= w_grant;
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign sched_valid      = r_valid;
    assign scheduler_thread = r_thread;
    assign draining         = w_draining;
    assign err_underflow    = r_err;

endmodule

// File: tb/tb_thread_scheduler.sv
module tb_thread_scheduler;

    localparam int NT   = 8;
    localparam int MAXI = 8;
    localparam int PIPE = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] thread_en;
    logic [7:0] stalled;
    logic       wb_valid;
    logic [2:0] wb_thread;
    logic       redirect_en;
    logic [2:0] redirect_thread;
    logic       exc_en;
    logic [2:0] exc_thread;
    logic       sched_valid;
    logic [2:0] scheduler_thread;
    logic [7:0] draining;
    logic       err_underflow;

    thread_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .thread_en        (thread_en),
        .stalled          (stalled),
        .wb_valid         (wb_valid),
        .wb_thread        (wb_thread),
        .redirect_en      (redirect_en),
        .redirect_thread  (redirect_thread),
        .exc_en           (exc_en),
        .exc_thread       (exc_thread),
        .sched_valid      (sched_valid),
        .scheduler_thread (scheduler_thread),
        .draining         (draining),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, one entry per thread.
    int  m_cnt [NT];
    bit  m_drain [NT];
    int  m_last;
    bit  m_valid;
    int  m_thread;
    bit  m_err;

    // Fetched instructions travel PIPE cycles before retiring.
    bit  pipe_v [PIPE];
    int  pipe_t [PIPE];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_cnt[t]   = 0;
            m_drain[t] = 0;
        end
        m_last   = NT - 1;
        m_valid  = 0;
        m_thread = 0;
        m_err    = 0;
    endtask

    function automatic bit eligible(int t);
        return thread_en[t] && !stalled[t] && !m_drain[t] && (m_cnt[t] < MAXI) &&
               !(redirect_en && int'(redirect_thread) == t) &&
               !(exc_en && int'(exc_thread) == t);
    endfunction

    task automatic model_edge();
        int win;
        bit hit, inc, dec;
        if (rst) begin
            model_reset();
            return;
        end
        win = -1;
        for (int k = 1; k <= NT; k++) begin
            if (win < 0 && eligible((m_last + k) % NT)) win = (m_last + k) % NT;
        end
        for (int t = 0; t < NT; t++) begin
            hit = (redirect_en && int'(redirect_thread) == t) || (exc_en && int'(exc_thread) == t);
            inc = (win == t);
            dec = wb_valid && int'(wb_thread) == t;
            if (!m_drain[t]) m_drain[t] = hit;
            else if (!hit && m_cnt[t] == 0) m_drain[t] = 0;
            if (inc && !dec) m_cnt[t]++;
            else if (dec && !inc) begin
                if (m_cnt[t] == 0) m_err = 1;
                else m_cnt[t]--;
            end
        end
        if (win >= 0) begin
            m_valid  = 1;
            m_thread = win;
            m_last   = win;
        end else begin
            m_valid = 0;
        end
    endtask

    function automatic logic [12:0] exp_bus();
        logic [7:0] d;
        for (int t = 0; t < NT; t++) d[t] = m_drain[t];
        return {m_valid, 3'(m_thread), d, m_err};
    endfunction

    task automatic tick();
        bit was_rst;
        was_rst = rst;
        model_edge();
        @(posedge clk);
        #1;
        for (int i = PIPE - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_t[i] = pipe_t[i-1];
        end
        pipe_v[0] = m_valid;
        pipe_t[0] = m_thread;
        if (was_rst) begin
            for (int i = 0; i < PIPE; i++) pipe_v[i] = 0;
        end
        cyc++;
    endtask

    task automatic pipe_retire();
        wb_valid  = pipe_v[PIPE-1];
        wb_thread = 3'(pipe_t[PIPE-1]);
    endtask

    task automatic quiet_inputs();
        stalled     = '0;
        wb_valid    = 0;
        wb_thread   = '0;
        redirect_en = 0;
        redirect_thread = '0;
        exc_en      = 0;
        exc_thread  = '0;
    endtask

    // Retire whatever the model says is still in flight, with fetch disabled.
    task automatic flush();
        int guard;
        quiet_inputs();
        thread_en = '0;
        guard = 0;
        for (int t = 0; t < NT; t++) begin
            while (m_cnt[t] > 0 && guard < 128) begin
                wb_valid  = 1;
                wb_thread = 3'(t);
                tick();
                guard++;
            end
        end
        wb_valid = 0;
        tick();
        tick();
        for (int i = 0; i < PIPE; i++) pipe_v[i] = 0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        thread_en = '0;
        rst = 1;
        tick();
        tick();
        n_cmp++;
        if ({sched_valid, scheduler_thread, draining, err_underflow} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_state got=%h required=0",
                     {sched_valid, scheduler_thread, draining, err_underflow});
        end
        $display("[%0d] reset v=%0b t=%0d drn=%h err=%0b", cyc, sched_valid, scheduler_thread, draining, err_underflow);
        rst = 0;
    endtask

    task automatic test_round_robin();
        quiet_inputs();
        thread_en = 8'hFF;
        for (int i = 0; i < 24; i++) begin
            pipe_retire();
            tick();
            n_cmp++;
            if ({sched_valid, scheduler_thread, draining, err_underflow} !== exp_bus()) begin
                n_bad++;
                $display("FAIL round_robin cyc=%0d got=%h required=%h", cyc,
                         {sched_valid, scheduler_thread, draining, err_underflow}, exp_bus());
            end
            if (i < 9) begin
                n_cmp++;
                if (!(sched_valid === 1'b1 && scheduler_thread === 3'(i % NT))) begin
                    n_bad++;
                    $display("FAIL rr_order cyc=%0d got v=%0b t=%0d required v=1 t=%0d",
                             cyc, sched_valid, scheduler_thread, i % NT);
                end
            end
            $display("[%0d] rr v=%0b t=%0d", cyc, sched_valid, scheduler_thread);
        end
        flush();
    endtask

    task automatic test_stall_skip();
        quiet_inputs();
        thread_en = 8'hFF;
        for (int i = 0; i < 30; i++) begin
            stalled = (i < 20) ? 8'b0000_0100 : 8'h00;
            pipe_retire();
            tick();
            n_cmp++;
            if ({sched_valid, scheduler_thread, draining, err_underflow} !== exp_bus()) begin
                n_bad++;
                $display("FAIL stall_skip cyc=%0d got=%h required=%h", cyc,
                         {sched_valid, scheduler_thread, draining, err_underflow}, exp_bus());
            end
            $display("[%0d] stall v=%0b t=%0d st=%h", cyc, sched_valid, scheduler_thread, stalled);
        end
        flush();
    endtask

    task automatic test_inflight_cap();
        int n_gr;
        quiet_inputs();
        thread_en = 8'h01;
        n_gr = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sched_valid === 1'b1) n_gr++;
            n_cmp++;
            if ({sched_valid, scheduler_thread, draining, err_underflow} !== exp_bus()) begin
                n_bad++;
                $display("FAIL cap_fill cyc=%0d got=%h required=%h", cyc,
                         {sched_valid, scheduler_thread, draining, err_underflow}, exp_bus());
            end
            $display("[%0d] cap v=%0b t=%0d", cyc, sched_valid, scheduler_thread);
        end
        n_cmp++;
        if (n_gr !== MAXI) begin
            n_bad++;
            $display("FAIL cap_grants got=%0d required=%0d", n_gr, MAXI);
        end
        wb_valid  = 1;
        wb_thread = 3'd0;
        tick();
        wb_valid = 0;
        n_gr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sched_valid === 1'b1) n_gr++;
            if (i == 0) begin
                n_cmp++;
                if (sched_valid !== 1'b1 || scheduler_thread !== 3'd0) begin
                    n_bad++;
                    $display("FAIL cap_refill_timing got v=%0b t=%0d required v=1 t=0",
                             sched_valid, scheduler_thread);
                end
            end
        end
        n_cmp++;
        if (n_gr !== 1) begin
            n_bad++;
            $display("FAIL cap_one_more got=%0d required=1", n_gr);
        end
        $display("[%0d] cap refill grants=%0d", cyc, n_gr);
        flush();
    endtask

    task automatic test_drain();
        quiet_inputs();
        thread_en = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            redirect_en = 0;
            exc_en      = 0;
            if (i == 10) begin
                redirect_en = 1; redirect_thread = 3'd3;
            end
            if (i == 16) begin
                redirect_en = 1; redirect_thread = 3'd5;
                exc_en = 1; exc_thread = 3'd5;
            end
            if (i == 24) begin
                redirect_en = 1; redirect_thread = 3'd1;
                exc_en = 1; exc_thread = 3'd6;
            end
            pipe_retire();
            tick();
            n_cmp++;
            if ({sched_valid, scheduler_thread, draining, err_underflow} !== exp_bus()) begin
                n_bad++;
                $display("FAIL drain cyc=%0d got=%h required=%h", cyc,
                         {sched_valid, scheduler_thread, draining, err_underflow}, exp_bus());
            end
            if (i == 10) begin
                n_cmp++;
                if (draining[3] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drain_enter got=%0b required=1", draining[3]);
                end
            end
            if (i == 24) begin
                n_cmp++;
                if (draining[1] !== 1'b1 || draining[6] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drain_two got=%b required=11", {draining[1], draining[6]});
                end
            end
            $display("[%0d] drain v=%0b t=%0d drn=%h err=%0b", cyc, sched_valid, scheduler_thread, draining, err_underflow);
        end
        flush();
    endtask

    task automatic test_underflow();
        quiet_inputs();
        thread_en = 8'h00;
        wb_valid  = 1;
        wb_thread = 3'd0;
        tick();
        wb_valid = 0;
        tick();
        n_cmp++;
        if (err_underflow !== 1'b1 || err_underflow !== m_err) begin
            n_bad++;
            $display("FAIL underflow_set got=%0b required=1", err_underflow);
        end
        $display("[%0d] underflow err=%0b", cyc, err_underflow);
        rst = 1;
        tick();
        rst = 0;
        n_cmp++;
        if (err_underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_clear got=%0b required=0", err_underflow);
        end
        thread_en = 8'hFF;
        tick();
        n_cmp++;
        if (sched_valid !== 1'b1 || scheduler_thread !== 3'd0) begin
            n_bad++;
            $display("FAIL first_after_rst got v=%0b t=%0d required v=1 t=0", sched_valid, scheduler_thread);
        end
        $display("[%0d] after rst v=%0b t=%0d", cyc, sched_valid, scheduler_thread);
        flush();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            thread_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            stalled     = 8'($urandom) & 8'($urandom) & 8'($urandom);
            redirect_en = ($urandom_range(0, 7) == 0);
            redirect_thread = 3'($urandom);
            exc_en      = ($urandom_range(0, 11) == 0);
            exc_thread  = 3'($urandom);
            rst         = ($urandom_range(0, 399) == 0);
            pipe_retire();
            tick();
            n_cmp++;
            if ({sched_valid, scheduler_thread, draining, err_underflow} !== exp_bus()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h required=%h", cyc,
                         {sched_valid, scheduler_thread, draining, err_underflow}, exp_bus());
            end
            $display("[%0d] rnd en=%h st=%h v=%0b t=%0d drn=%h err=%0b", cyc, thread_en, stalled,
                     sched_valid, scheduler_thread, draining, err_underflow);
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        model_reset();
        for (int i = 0; i < PIPE; i++) begin
            pipe_v[i] = 0;
            pipe_t[i] = 0;
        end
        test_reset();
        test_round_robin();
        test_stall_skip();
        test_inflight_cap();
        test_drain();
        test_underflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
Per-cycle fetch-thread selector for the multithreaded pipeline. It drives scheduler_thread into the IF stage, choosing round-robin among threads that are enabled, not stalled by the d-cache, not draining after a redirect or exception, and under their in-flight instruction cap. It tracks in-flight instructions per thread from fetch grant to writeback, so a redirected thread resumes fetch only once its stale instructions have left the pipeline.

Parameters:
N_THREADS, 8, number of hardware threads; equals common::n_threads
TID_W, 3, thread id width; equals $bits(threadid_t)
MAX_INFLIGHT, 8, max issued-but-not-retired instructions per thread; minimum 1
CNT_W, 4, in-flight counter width; must hold MAX_INFLIGHT

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
thread_en  in  N_THREADS  per-thread enable mask; 0 = never granted
stalled  in  N_THREADS  per-thread stall from TL stage (d-cache miss)
wb_valid  in  1  an instruction (valid or not) leaves the TL/WB boundary this cycle
wb_thread  in  TID_W  thread of that instruction
redirect_en  in  1  commit logic changed the thread PC (taken jump/branch or retry)
redirect_thread  in  TID_W  thread redirected
exc_en  in  1  exception raised
exc_thread  in  TID_W  faulting thread
sched_valid  out  1  scheduler_thread is a real grant this cycle
scheduler_thread  out  TID_W  thread to fetch this cycle
draining  out  N_THREADS  per-thread DRAIN state, for debug/commit
err_underflow  out  1  sticky: retire seen with counter at 0

Behaviour:
- Reset: all outputs 0. Counters 0. All threads in RUN. RR pointer last = N_THREADS-1, so thread 0 wins first.
- Eligibility (combinational, current cycle): elig[t] = thread_en[t] & ~stalled[t] & state[t]==RUN & cnt[t] < MAX_INFLIGHT & ~(redirect_en & redirect_thread==t) & ~(exc_en & exc_thread==t).
- Grant: the first eligible thread scanning last+1, last+2, ... with wrap modulo N_THREADS. It registers at the edge: sched_valid<=1, scheduler_thread<=winner, last<=winner. Latency: inputs at cycle t, grant visible at cycle t+1.
- No eligible thread: sched_valid<=0. scheduler_thread and last hold.
- Counter update per thread each edge: +1 if granted, -1 if wb_valid & wb_thread==t. Both at once: unchanged.
- Retire when the counter is 0: the counter stays 0 and err_underflow<=1 (sticky until rst).
- A counter never exceeds MAX_INFLIGHT, because the eligibility check blocks the grant.
- Per-thread FSM, two states:
  - RUN -> DRAIN on (redirect_en|exc_en) targeting t.
  - DRAIN -> RUN at the edge when cnt[t]==0 and there is no new redirect/exc for t.
  - DRAIN + new redirect/exc: stays in DRAIN.
- redirect and exc for the same thread in the same cycle: one DRAIN entry, no error.
- redirect and exc for different threads in the same cycle: both threads enter DRAIN.
- Retires during DRAIN decrement the counter normally; those instructions are the stale ones.
- Disabling thread_en[t] stops new grants only. The counter and FSM keep tracking.
- rst mid-operation: everything returns to reset values at that edge. Retires arriving later may set err_underflow; the bench must hold wb_valid=0 for pipeline depth after reset.

Decomposition:
- Reuse common::threadid_t and common::n_threads.
- Add to the common package: sched_state_t enum {SCHED_RUN, SCHED_DRAIN}; the default max_inflight constant.
- Natural sub-module: rr_arbiter (N-bit request vector + last pointer -> one-hot/index grant + any), which is pure combinational. The per-thread counters and FSM stay in thread_scheduler.

Test Plan:
- Reset, thread_en=8'hFF, no stalls, retire every grant 8 cycles later -> grants 0,1,...,7,0 repeating; sched_valid=1 from cycle 1.
- thread_en=8'hFF, stalled=8'b0000_0100 -> sequence 0,1,3,4,5,6,7,0 (thread 2 skipped); clearing stalled[2] while last=1 -> next grant 2.
- MAX_INFLIGHT=2, thread_en=8'h01, no retires -> two grants of thread 0, then sched_valid=0. One retire on thread 0 -> exactly one more grant, the cycle after the retire.
- Thread 3 has cnt=3; redirect_en with thread 3 -> draining[3]=1 and no grants to thread 3. After 3 retires (cnt=0), the next edge gives draining[3]=0; thread 3 is granted again on its RR turn.
- Same cycle: exc_en for thread 5, redirect_en for thread 5, and a retire with cnt[5]=1 -> single DRAIN; exit the edge after cnt reaches 0; err_underflow stays 0.
- thread_en=8'h01, cnt[0]=0, wb_valid with wb_thread=0 -> err_underflow=1, cnt stays 0. rst -> err_underflow=0 and the first grant is thread 0.
